// File: rtl/serial_tx_fifo.sv
// Buffered serial transmitter: a small FIFO feeds an 8N1-style framer with
// optional even/odd parity and one or two stop bits, all timed in clk cycles.
module serial_tx_fifo #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 3,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop2,
    input  logic [DATA_W-1:0]             din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [2:0]                    state_dbg
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BCNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_W);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // Handshake: a word is taken on any rising edge where din_valid && din_ready.
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_en, pop;

    state_t            state_q, state_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_en_q, par_en_d, par_bit_q, par_bit_d;
    logic              stop2_q, stop2_d;
    logic              tx_q, tx_d;
    logic              bit_end;
    logic [DATA_W-1:0] head;

    assign din_ready  = count_q < CNT_W'(FIFO_DEPTH);
    assign wr_en      = din_valid && din_ready;
    assign fifo_count = count_q;
    assign busy       = state_q != S_IDLE;
    assign tx         = tx_q;
    assign state_dbg  = state_q;
    assign bit_end    = bcnt_q == BCNT_W'(CLKS_PER_BIT - 1);
    assign head       = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= din;
    end

    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // tx_d is the line level for the state being entered, so tx leaves a flop.
    always_comb begin
        state_d   = state_q;
        bcnt_d    = (state_q == S_IDLE || bit_end) ? '0 : bcnt_q + BCNT_W'(1);
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) pop = 1'b1;
            end
            S_START: if (bit_end) begin
                state_d = S_DATA;
                idx_d   = '0;
                tx_d    = shreg_q[0];
            end
            S_DATA: if (bit_end) begin
                shreg_d = shreg_q >> 1;
                if (idx_q == IDX_W'(DATA_W - 1)) begin
                    idx_d   = '0;
                    state_d = par_en_q ? S_PARITY : S_STOP;
                    tx_d    = par_en_q ? par_bit_q : 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    tx_d  = shreg_q[1];
                end
            end
            S_PARITY: if (bit_end) begin
                state_d = S_STOP;
                idx_d   = '0;
                tx_d    = 1'b1;
            end
            S_STOP: if (bit_end) begin
                if (stop2_q && idx_q == '0) begin
                    idx_d = IDX_W'(1);
                end else begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                    if (count_q != '0) pop = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Frame settings are captured with the word so later input changes
        // cannot disturb a frame already in flight.
        if (pop) begin
            state_d   = S_START;
            bcnt_d    = '0;
            shreg_d   = head;
            par_en_d  = ^parity_mode;
            par_bit_d = (^head) ^ (parity_mode == 2'b10);
            stop2_d   = stop2;
            tx_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            bcnt_q    <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q   <= count_d;
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
        end
    end
endmodule

// File: tb/tb_serial_tx_fifo.sv
// Bench for serial_tx_fifo: frame-level reference model feeding a scoreboard
// queue, a serial-line monitor that decodes frames, and per-cycle status checks.
module tb_serial_tx_fifo;
    localparam int DATA_W = 8;
    localparam int CPB    = 3;
    localparam int DEPTH  = 4;
    localparam int FW     = DATA_W + 3;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [1:0]                 parity_mode = 2'b00;
    logic                       stop2 = 1'b0;
    logic [DATA_W-1:0]          din = '0;
    logic                       din_valid = 1'b0;
    logic                       din_ready, tx, busy, done;
    logic [$clog2(DEPTH):0]     fifo_count;
    logic [2:0]                 state_dbg;

    serial_tx_fifo #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .parity_mode(parity_mode), .stop2(stop2),
        .din(din), .din_valid(din_valid), .din_ready(din_ready), .tx(tx),
        .busy(busy), .done(done), .fifo_count(fifo_count), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Frame descriptor {stop2, parity_mode, data}
    function automatic int frame_len(input logic [FW-1:0] f);
        logic [1:0] pm = f[DATA_W +: 2];
        int par = (pm == 2'b01 || pm == 2'b10) ? 1 : 0;
        return CPB * (2 + DATA_W + par + int'(f[FW-1]));
    endfunction

    function automatic logic exp_bit(input logic [FW-1:0] f, input int i);
        int b = i / CPB;
        logic [DATA_W-1:0] d = f[DATA_W-1:0];
        logic [1:0] pm = f[DATA_W +: 2];
        logic par_en = (pm == 2'b01 || pm == 2'b10);
        if (b == 0) return 1'b0;
        if (b <= DATA_W) return d[b-1];
        if (par_en && b == DATA_W + 1) return (^d) ^ (pm == 2'b10);
        return 1'b1;
    endfunction

    // reference model: buffered words plus cycles left in the current frame
    logic [DATA_W-1:0] m_fifo[$];
    int                m_rem = 0;
    logic [FW-1:0]     exp_q[$];
    logic [FW-1:0]     m_f;
    bit                m_pop, m_wr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fifo.delete();
            exp_q.delete();
            m_rem = 0;
        end else begin
            m_pop = (m_fifo.size() > 0) && (m_rem <= 1);
            m_wr  = din_valid && (m_fifo.size() < DEPTH);
            if (m_pop) begin
                m_f = {stop2, parity_mode, m_fifo.pop_front()};
                exp_q.push_back(m_f);
                m_rem = frame_len(m_f);
            end else if (m_rem > 0) begin
                m_rem--;
            end
            if (m_wr) m_fifo.push_back(din);
        end
    end

    // per-cycle status checks
    always @(negedge clk) begin
        check("din_ready", int'(din_ready), int'(m_fifo.size() < DEPTH));
        check("fifo_count", int'(fifo_count), m_fifo.size());
        check("busy", int'(busy), int'(m_rem != 0));
        check("done", int'(done), int'(m_rem == 1));
        if (m_rem == 0) check("tx_idle", int'(tx), 1);
    end

    // scoreboard monitor: decode each frame on the line against exp_q
    initial begin
        logic [FW-1:0] fr;
        int errs, len;
        bit aborted;
        forever begin
            @(negedge clk);
            if (rst || tx !== 1'b0) continue;
            if (exp_q.size() == 0) begin
                check("frame_unexpected", 1, 0);
                continue;
            end
            fr = exp_q.pop_front();
            len = frame_len(fr);
            errs = 0;
            aborted = 1'b0;
            for (int i = 0; i < len; i++) begin
                if (i > 0) @(negedge clk);
                if (rst) begin
                    aborted = 1'b1;
                    break;
                end
                if (tx !== exp_bit(fr, i)) errs++;
            end
            if (!aborted) check("frame_bits", errs, 0);
        end
    end

    // driver tasks
    task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                         input logic [1:0] pm, input logic s2);
        din_valid = v;
        din = d;
        parity_mode = pm;
        stop2 = s2;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns edges from the write edge until done is seen (-1 on timeout).
    task automatic send_and_time(input logic [DATA_W-1:0] d, input logic [1:0] pm,
                                 input logic s2, output int n);
        drive(1'b1, d, pm, s2);
        din_valid = 1'b0;
        n = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic drain(input string name);
        int ok = 0;
        din_valid = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk);
            #1;
            if (m_fifo.size() == 0 && m_rem == 0) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
        idle(2);
    endtask

    initial begin
        int n, t1, t2;
        #12;
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_ready", int'(din_ready), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(3);

        // 0xA5, no parity, one stop: latency then a 30-cycle frame
        drive(1'b1, 8'hA5, 2'b00, 1'b0);
        check("lat_count", int'(fifo_count), 1);
        check("lat_tx_high", int'(tx), 1);
        idle(1);
        check("lat_tx_low", int'(tx), 0);
        n = -1;
        for (int k = 2; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = k;
                break;
            end
        end
        check("len_a5", n, 30);
        idle(1);
        check("a5_busy_after", int'(busy), 0);
        idle(2);

        send_and_time(8'h07, 2'b01, 1'b0, n);
        check("len_even_07", n, 33);
        idle(2);
        send_and_time(8'h07, 2'b10, 1'b0, n);
        check("len_odd_07", n, 33);
        idle(2);
        send_and_time(8'h00, 2'b00, 1'b1, n);
        check("len_stop2_00", n, 33);
        idle(2);

        // back-to-back frames: done pulses one frame apart
        drive(1'b1, 8'h11, 2'b00, 1'b0);
        drive(1'b1, 8'h22, 2'b00, 1'b0);
        din_valid = 1'b0;
        t1 = -1;
        t2 = -1;
        for (int k = 1; k <= 150; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (t1 < 0) t1 = k;
                else begin
                    t2 = k;
                    break;
                end
            end
        end
        check("b2b_done_gap", t2 - t1, 30);
        drain("drain_b2b");

        // overfill while busy: the model decides which words are accepted
        drive(1'b1, 8'h81, 2'b01, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h90 + i), 2'b10, 1'b1);
        idle(1);
        check("full_ready", int'(din_ready), 0);
        drain("drain_full");

        // reset mid-frame with words still buffered
        drive(1'b1, 8'h5A, 2'b01, 1'b0);
        drive(1'b1, 8'h66, 2'b00, 1'b0);
        idle(8);
        #2 rst = 1'b1;
        #1;
        check("abort_tx", int'(tx), 1);
        check("abort_count", int'(fifo_count), 0);
        check("abort_done", int'(done), 0);
        check("abort_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(6);
        send_and_time(8'h3C, 2'b00, 1'b0, n);
        check("len_after_rst", n, 30);
        idle(2);

        // randomized traffic with settings changing every cycle
        for (int i = 0; i < 900; i++)
            drive($urandom_range(0, 99) < 35, 8'($urandom), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
        drain("drain_random");
        check("exp_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/serial_tx_fifo.md
SERIAL_TX_FIFO -- requirements
Module: serial_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 8, meaning data bits per frame, legal 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 3, meaning clk cycles per serial bit, legal >= 2.
REQ-003 Parameter FIFO_DEPTH, default 4, meaning transmit buffer entries, power of 2, >= 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 parity_mode  input  2  frame parity: 00 none, 01 even, 10 odd, 11 none.
REQ-007 stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-008 din  input  DATA_W  word to enqueue.
REQ-009 din_valid  input  1  enqueue request.
REQ-010 din_ready  output  1  FIFO can accept a word this cycle.
REQ-011 tx  output  1  serial line, idle high.
REQ-012 busy  output  1  a frame is on the line (FSM not in IDLE).
REQ-013 done  output  1  one-cycle pulse at end of each frame.
REQ-014 fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently buffered.

Function
REQ-015 din_ready SHALL equal (fifo_count < FIFO_DEPTH); a word is written on a clk edge where din_valid && din_ready.
REQ-016 din_valid while full SHALL be ignored: no write, no corruption of stored words.
REQ-017 Simultaneous write and pop SHALL leave fifo_count unchanged; FIFO order strictly first-in-first-out, pointers wrap modulo FIFO_DEPTH.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; every non-IDLE bit lasts exactly CLKS_PER_BIT cycles, timed by an internal bit counter.
REQ-019 IDLE with fifo_count > 0 SHALL pop the head word and enter START on the next edge; parity_mode and stop2 SHALL be latched at that pop and held for the whole frame.
REQ-020 Latency: a word written into an empty FIFO while IDLE SHALL drive tx low one cycle after fifo_count becomes 1.
REQ-021 tx SHALL be 0 in START, data bit (LSB first) in DATA, parity bit in PARITY, 1 in STOP and IDLE.
REQ-022 DATA SHALL send exactly DATA_W bits; then PARITY if latched mode is 01/10, else STOP directly.
REQ-023 Parity bit SHALL be XOR of data bits for even, its inverse for odd.
REQ-024 STOP SHALL last 1 or 2 bit periods per latched stop2.
REQ-025 done SHALL pulse for the last cycle of the final stop bit period.
REQ-026 At end of STOP with fifo_count > 0, FSM SHALL pop and enter START directly (no idle cycle between frames); else enter IDLE.
REQ-027 Changing parity_mode/stop2 mid-frame SHALL not affect the current frame.
REQ-028 tx SHALL be registered (glitch-free).

Reset
REQ-029 rst high SHALL immediately force tx=1, busy=0, done=0, fifo_count=0, din_ready=1, FSM=IDLE, and discard buffered words.
REQ-030 rst asserted mid-frame SHALL abort the frame with no done pulse; after release, line stays idle until a new write.

Verification
REQ-031 Defaults, parity 00, stop2=0, write 0xA5 -> tx 0,1,0,1,0,0,1,0,1,1 for 3 cycles each (30 cycles), done on cycle 30, busy low after.
REQ-032 parity 01, write 0x07 -> 11-bit frame, parity bit 1; repeat with parity 10 -> parity bit 0.
REQ-033 stop2=1, write 0x00 -> stop high 6 cycles, frame length 33 cycles.
REQ-034 Write 0x11,0x22 back-to-back -> second start bit begins the cycle after first frame's last stop cycle; two done pulses 30 cycles apart.
REQ-035 While busy, write 5 words with DEPTH 4 -> din_ready low at count 4, fifth word dropped unless a pop coincides; transmitted order matches accepted order.
REQ-036 Assert rst at cycle 10 of a frame -> tx=1 same cycle, fifo_count=0, no done; write 0x3C after release -> normal frame.
